// File: rtl/reg_arb_pkg.sv
// Shared constants, port IDs and FSM encoding for the two-port register-bank write arbiter.
package reg_arb_pkg;

  localparam int unsigned MAX_ADDR = 4;
  localparam int unsigned NUM_REGS = 5;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

endpackage

// File: rtl/reg_arbiter_if.sv
// Write-request bus of the register arbiter: port A (SPI decoder) and port B (local sequencer).
interface reg_arbiter_if;
  import reg_arb_pkg::*;

  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              err;

  modport master (
    output a_req, a_addr, a_wdata, b_req, b_addr, b_wdata,
    input  a_gnt, b_gnt, err
  );

  modport slave (
    input  a_req, a_addr, a_wdata, b_req, b_addr, b_wdata,
    output a_gnt, b_gnt, err
  );

endinterface

// File: rtl/rr_arb2.sv
// Stateless two-way round-robin pick; the caller holds the most-recently-granted port ID.
module rr_arb2
  import reg_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_id,
  output logic       grant_id
);

  always_comb begin
    grant_id = PORT_A;
    case (req)
      2'b10:   grant_id = PORT_B;
      2'b11:   grant_id = ~last_id;
      default: grant_id = PORT_A;
    endcase
  end

endmodule

// File: rtl/reg_arbiter.sv
// Two-port register-bank write arbiter with round-robin and a saturating conflict counter.
// Optional readback port enabled by defining REG_ARB_READBACK_EN.
module reg_arbiter
  import reg_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  reg_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] data3,
  output logic [DATA_W-1:0] data4,
  output logic [7:0]        conflict_cnt
`ifdef REG_ARB_READBACK_EN
  ,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
`endif
);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_a_gnt, r_b_gnt, r_err;
  logic              r_rr_ptr;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_data [NUM_REGS];

  logic [1:0]        w_req;
  logic              w_grant_id;
  logic              w_take;
  logic              w_both;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [DATA_W-1:0] w_wdata_sel;

  assign w_req       = {bus.b_req, bus.a_req};
  assign w_take      = (r_state == StIdle) && (|w_req);
  assign w_both      = (r_state == StIdle) && (&w_req);
  assign w_addr_sel  = (w_grant_id == PORT_B) ? bus.b_addr : bus.a_addr;
  assign w_wdata_sel = (w_grant_id == PORT_B) ? bus.b_wdata : bus.a_wdata;

  // r_rr_ptr names the port that wins the next tie, so the other one was granted last.
  rr_arb2 u_rr_arb2 (
    .req      (w_req),
    .last_id  (~r_rr_ptr),
    .grant_id (w_grant_id)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (|w_req) w_state_nxt = StGrant;
      StGrant: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_a_gnt  <= 1'b0;
      r_b_gnt  <= 1'b0;
      r_err    <= 1'b0;
      r_rr_ptr <= PORT_A;
      r_cnt    <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) r_data[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a_gnt <= w_take && (w_grant_id == PORT_A);
      r_b_gnt <= w_take && (w_grant_id == PORT_B);
      r_err   <= w_take && (w_addr_sel > ADDR_W'(MAX_ADDR));
      if (w_take) begin
        r_addr   <= w_addr_sel;
        r_wdata  <= w_wdata_sel;
        r_rr_ptr <= ~w_grant_id;
      end
      if (w_both && (r_cnt != 8'hFF)) r_cnt <= r_cnt + 8'd1;
      if ((r_state == StGrant) && (r_addr <= ADDR_W'(MAX_ADDR))) begin
        r_data[r_addr[2:0]] <= r_wdata;
      end
    end
  end

  // A reset landing on the GRANT cycle suppresses the grant pulse already on the wire.
  assign bus.a_gnt = r_a_gnt & ~rst;
  assign bus.b_gnt = r_b_gnt & ~rst;
  assign bus.err   = r_err & ~rst;

  assign data0        = r_data[0];
  assign data1        = r_data[1];
  assign data2        = r_data[2];
  assign data3        = r_data[3];
  assign data4        = r_data[4];
  assign conflict_cnt = r_cnt;

`ifdef REG_ARB_READBACK_EN
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (rd_addr <= ADDR_W'(MAX_ADDR)) begin
      r_rd_data <= r_data[rd_addr[2:0]];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign rd_data = r_rd_data;
`endif

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 The block SHALL declare its ports as follows; the clock is clk, the reset is rst, and there is one clock with a synchronous, active-high reset:
- clk  input  1  sole clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- a_req  input  1  port A (SPI decoder) write request, held until granted
- a_addr  input  7  port A register address
- a_wdata  input  8  port A write data
- a_gnt  output  1  port A one-cycle grant pulse
- b_req  input  1  port B (local sequencer) write request, held until granted
- b_addr  input  7  port B register address
- b_wdata  input  8  port B write data
- b_gnt  output  1  port B one-cycle grant pulse
- err  output  1  one-cycle pulse, coincident with the grant, when the granted address exceeds MAX_ADDR
- data0..data4  output  8 each  register bank contents
- conflict_cnt  output  8  saturating count of simultaneous requests

Function
REQ-002 The FSM SHALL have two states: IDLE and GRANT.
REQ-003 In IDLE, with a_req or b_req high, the FSM SHALL select one port, latch that port's addr and wdata, and move to GRANT at the next edge.
REQ-004 In GRANT, the FSM SHALL pulse the selected gnt high for exactly one cycle and return to IDLE unconditionally.
REQ-005 In GRANT, if the latched addr is 0..4, data[addr] SHALL take the latched wdata, visible on the cycle after GRANT.
REQ-006 If the latched addr is greater than 4, err SHALL pulse with gnt and no register SHALL change.
REQ-007 Requests SHALL NOT be sampled in GRANT; a requester SHALL drop or replace req in the cycle its gnt is high, giving a maximum throughput of one write per 2 cycles.
REQ-008 If exactly one port requests in IDLE, that port SHALL win.
REQ-009 If both ports request in IDLE, the port not granted most recently SHALL win (round-robin); after reset, port A SHALL have priority.
REQ-010 Each IDLE cycle with both a_req and b_req high SHALL increment conflict_cnt by 1, saturating at 255 with no wrap.
REQ-011 a_gnt, b_gnt and err SHALL never be high in the same cycle for both ports.
REQ-012 gnt, err and data0..data4 SHALL be driven from registers, with no combinational path from the inputs.

Reset
REQ-013 While rst is high at a clock edge: state = IDLE, data0..data4 = 0, a_gnt = b_gnt = err = 0, conflict_cnt = 0, round-robin pointer = port A.
REQ-014 If rst is asserted while in GRANT, the pending write SHALL be discarded and no gnt SHALL be issued.
REQ-015 Requests held across reset deassertion SHALL be arbitrated normally from the first cycle after rst falls.

Configuration
REQ-016 With macro REG_ARB_READBACK_EN defined, the block SHALL add input rd_addr (7 bits) and output rd_data (8 bits).
REQ-017 With REG_ARB_READBACK_EN defined, rd_data SHALL equal data[rd_addr] one cycle later, or 0 for an out-of-range rd_addr.
REQ-018 A read of a register written in the same cycle SHALL return the old value.
REQ-019 With REG_ARB_READBACK_EN defined, rd_data SHALL reset to 0.
REQ-020 Without REG_ARB_READBACK_EN, these ports and their logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-021 Shared package reg_arb_pkg SHALL hold MAX_ADDR = 4, NUM_REGS = 5, the FSM state encoding, and the port-ID constants PORT_A and PORT_B.
REQ-022 The two-way round-robin selection SHALL be a sub-module rr_arb2 with inputs req[1:0] and last_id, output grant_id, and no internal state; the pointer is held in reg_arbiter.

Verification
REQ-023 Single write: a_req with addr 2, wdata 0xA5 -> a_gnt high on the 2nd cycle, data2 = 0xA5 on the 3rd, err = 0.
REQ-024 Collision: a_req and b_req together (A addr 0 = 0x11, B addr 1 = 0x22), both held -> A granted first, then B after 2 cycles; data0 = 0x11, data1 = 0x22; conflict_cnt = 1.
REQ-025 Out of range: b_req with addr 5, wdata 0xFF -> b_gnt and err pulse together; data0..data4 unchanged.
REQ-026 Saturation: both ports continuously requesting for more than 600 cycles -> conflict_cnt = 255 and stays there; grants alternate A, B, A, B.
REQ-027 Reset mid-operation: rst asserted in the GRANT cycle of a write 0x5A to addr 3 -> no gnt, data3 = 0, state IDLE.
REQ-028 Readback (REG_ARB_READBACK_EN defined): write 0x3C to addr 4, then rd_addr = 4 -> rd_data = 0x3C one cycle later; rd_addr = 9 -> rd_data = 0.
